// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the write port of one async FIFO (wr_clk domain)
// among N requesters. Round-robin arbitration with burst locking; every word
// written is tagged with the requester ID for routing on the read side.
//
// Build option: define FIFO_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest index wins, rr_ptr held at 0). Burst locking and
// MAX_BURST apply in both modes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no grant, no writes; picks a winner when any req_valid is set
// S_BURST | one requester owns the port until its last beat or MAX_BURST
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 16
) (
  input  logic              wr_clk,
  input  logic              reset_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N-1:0]      req_last,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [IDW+DW-1:0] fifo_data,
  output logic [N-1:0]      grant,
  output logic              busy
);

  // beat_cnt only needs to reach MAX_BURST-1; keep at least one bit so
  // MAX_BURST=1 still elaborates.
  localparam int            CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BEAT_TC  = CW'(MAX_BURST - 1);
  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           granted_valid;
  logic           granted_last;
  logic           beat;
  logic [DW-1:0]  granted_data;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest valid index is the last writer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        win_found = 1'b1;
        win_idx   = IDW'(k);
      end
    end
  end
`else
  logic [IDW:0]   rr_cand;
  logic [IDW-1:0] rr_next;

  // Round-robin: first valid requester at or after rr_ptr, wrapping at N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_cand   = '0;
    for (int k = 0; k < N; k++) begin
      rr_cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (rr_cand >= (IDW+1)'(N)) begin
        rr_cand = rr_cand - (IDW+1)'(N);
      end
      if (!win_found && req_valid[rr_cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_cand[IDW-1:0];
      end
    end
  end

  // Pointer moves to the requester after the one just released (mod N).
  always_comb begin
    rr_next = (gid_q == IDW'(N - 1)) ? '0 : gid_q + 1'b1;
  end
`endif

  // Pick out the granted requester's valid/last/payload with the one-hot grant.
  always_comb begin
    granted_valid = |(grant_q & req_valid);
    granted_last  = |(grant_q & req_last);
    granted_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        granted_data = granted_data | req_data[i*DW +: DW];
      end
    end
    beat = (state_q == S_BURST) && granted_valid && !fifo_full;
  end

  // Combinational write path; everything is forced to zero outside a burst.
  always_comb begin
    fifo_wr_en = beat;
    req_ready  = '0;
    fifo_data  = '0;
    if (state_q == S_BURST) begin
      req_ready = grant_q & {N{!fifo_full}};
      fifo_data = {gid_q, granted_data};
    end
    grant = grant_q;
    busy  = (state_q == S_BURST);
  end

  // Next-state logic: grant on arbitration win, release on last beat or burst cap.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gid_d      = gid_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d    = S_BURST;
          grant_d    = ONE_HOT0 << win_idx;
          gid_d      = win_idx;
          beat_cnt_d = '0;
        end
      end
      S_BURST: begin
        // A stalled beat (FIFO full or requester bubble) freezes everything.
        if (beat) begin
          if (granted_last || (beat_cnt_q == BEAT_TC)) begin
            state_d    = S_IDLE;
            grant_d    = '0;
            gid_d      = '0;
            beat_cnt_d = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
            rr_ptr_d   = '0;
`else
            rr_ptr_d   = rr_next;
`endif
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        gid_d      = '0;
        beat_cnt_d = '0;
        rr_ptr_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any partial burst immediately.
  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gid_q      <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gid_q      <= gid_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Structural invariants of the grant and write path.
  a_grant_onehot0: assert property (@(posedge wr_clk) disable iff (!reset_n)
    $onehot0(grant_q));
  a_grant_iff_burst: assert property (@(posedge wr_clk) disable iff (!reset_n)
    ((state_q == S_BURST) == (grant_q != '0)));
  a_no_write_when_full: assert property (@(posedge wr_clk) disable iff (!reset_n)
    (fifo_full |-> !fifo_wr_en));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Requesters are modelled as beat
// queues; each loaded beat is also pushed to a per-requester expected queue
// that is popped when the beat appears on the FIFO write port.
module tb_fifo_wr_arbiter;

  localparam int N         = 4;
  localparam int DW        = 32;
  localparam int IDW       = 2;
  localparam int MAX_BURST = 16;

  logic              wr_clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [IDW+DW-1:0] fifo_data;
  logic [N-1:0]      grant;
  logic              busy;

  fifo_wr_arbiter #(.N(N), .DW(DW), .IDW(IDW), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk     (wr_clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 wr_clk = ~wr_clk;

  logic [DW:0]   src_q [N][$];
  logic [DW-1:0] exp_q [N][$];
  logic [N-1:0]  grant_log [$];
  int            beats_log [$];
  int            wr_cycles [$];
  int            cyc;
  logic          prev_busy;
  logic [N-1:0]  last_grant;
  int            n_checks;
  int            n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int written_now();
    int s;
    s = 0;
    foreach (beats_log[k]) s += beats_log[k];
    return s;
  endfunction

  task automatic drive();
    logic [DW:0] head;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        head = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_last[i]           = head[DW];
        req_data[i*DW +: DW]  = head[DW-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic load(input int id, input int nbeats, input bit with_last);
    logic [DW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = {8'(id), 8'(b), 16'($urandom_range(0, 65535))};
      src_q[id].push_back({(with_last && (b == nbeats - 1)), d});
      exp_q[id].push_back(d);
    end
    drive();
  endtask

  // One clock: sample at negedge, then apply accepted beats after the posedge.
  task automatic step();
    logic [N-1:0]   acc;
    logic [IDW-1:0] id;
    logic [DW-1:0]  e;
    @(negedge wr_clk);
    cyc++;
    acc        = req_valid & req_ready;
    last_grant = grant;
    if (busy && !prev_busy) begin
      grant_log.push_back(grant);
      beats_log.push_back(0);
    end
    prev_busy = busy;
    if (fifo_full) begin
      check("wr_en_while_full", 64'(fifo_wr_en), 64'(0));
      check("ready_while_full", 64'(req_ready), 64'(0));
    end
    if (fifo_wr_en) begin
      id = fifo_data[IDW+DW-1:DW];
      check("wr_ready_onehot", 64'(req_ready), 64'(onehot(int'(id))));
      check("wr_expected", 64'(exp_q[id].size() != 0), 64'(1));
      if (exp_q[id].size() != 0) begin
        e = exp_q[id].pop_front();
        check("wr_data", 64'(fifo_data), 64'({id, e}));
      end
      if (beats_log.size() > 0) beats_log[beats_log.size()-1]++;
      wr_cycles.push_back(cyc);
    end
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic run(input string tag, input int max_cycles, input bit need_idle);
    int n;
    n = 0;
    while (!(all_empty() && (!need_idle || !busy)) && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, 64'(all_empty() && (!need_idle || !busy)), 64'(1));
  endtask

  task automatic clear_logs();
    grant_log.delete();
    beats_log.delete();
    wr_cycles.delete();
    prev_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic check_burst(input int k, input int gid, input int beats);
    if (k < grant_log.size()) begin
      check("burst_grant", 64'(grant_log[k]), 64'(onehot(gid)));
      check("burst_beats", 64'(beats_log[k]), 64'(beats));
    end else begin
      check("burst_present", 64'(grant_log.size()), 64'(k + 1));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"},     64'(grant), 64'(0));
    check({tag, "_busy"},      64'(busy), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_wr_en"},     64'(fifo_wr_en), 64'(0));
    check({tag, "_data"},      64'(fifo_data), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5];
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    prev_busy  = 1'b0;
    last_grant = '0;
    reset_n    = 1'b0;
    fifo_full  = 1'b0;
    req_valid  = '1;
    req_last   = '0;
    req_data   = '1;
    #3;
    check_zero_outputs("reset");
    drive();
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    reset_n = 1'b1;
    clear_logs();

    // Test 1: req0 alone, 3-beat burst.
    load(0, 3, 1'b1);
    run("t1_done", 50, 1'b1);
    check("t1_bursts", 64'(grant_log.size()), 64'(1));
    check_burst(0, 0, 3);
    do_reset();

    // Test 2: all requesters with single-beat bursts, req0 twice.
    load(0, 1, 1'b1);
    load(0, 1, 1'b1);
    load(1, 1, 1'b1);
    load(2, 1, 1'b1);
    load(3, 1, 1'b1);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    run("t2_done", 50, 1'b1);
    check("t2_bursts", 64'(grant_log.size()), 64'(5));
    for (int k = 0; k < 5; k++) check_burst(k, exp_order[k], 1);
    for (int k = 1; k < wr_cycles.size(); k++) begin
      check("t2_wr_spacing", 64'(wr_cycles[k] - wr_cycles[k-1]), 64'(2));
    end
    do_reset();

    // Test 3: FIFO full for 5 cycles in the middle of a req2 burst.
    begin
      int n;
      load(2, 6, 1'b1);
      n = 0;
      while (written_now() < 2 && n < 20) begin
        step();
        n++;
      end
      check("t3_reach_beat2", 64'(written_now()), 64'(2));
      fifo_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
        step();
        check("t3_grant_held", 64'(last_grant), 64'(4'b0100));
      end
      check("t3_beats_frozen", 64'(written_now()), 64'(2));
      fifo_full = 1'b0;
      run("t3_done", 50, 1'b1);
      check("t3_bursts", 64'(grant_log.size()), 64'(1));
      check_burst(0, 2, 6);
    end
    do_reset();

    // Test 4: req1 streams 20 beats without last; forced release after 16.
    load(1, 20, 1'b0);
    run("t4_done", 100, 1'b0);
    check("t4_bursts", 64'(grant_log.size()), 64'(2));
    check_burst(0, 1, MAX_BURST);
    check_burst(1, 1, 20 - MAX_BURST);
    do_reset();

    // Test 5: move rr_ptr to 3, then reset in the middle of a req3 burst.
    begin
      int n;
      load(2, 1, 1'b1);
      run("t5_pre_done", 20, 1'b1);
      clear_logs();
      load(3, 4, 1'b1);
      load(1, 2, 1'b1);
      n = 0;
      while (written_now() < 1 && n < 20) begin
        step();
        n++;
      end
      check("t5_beat2_wr_en", 64'(fifo_wr_en), 64'(1));
      check("t5_beat2_grant", 64'(grant), 64'(4'b1000));
      #1;
      reset_n = 1'b0;
      #1;
      check_zero_outputs("t5_async_reset");
      @(posedge wr_clk);
      @(posedge wr_clk);
      #1;
      reset_n = 1'b1;
      clear_logs();
      run("t5_done", 60, 1'b1);
      check("t5_bursts", 64'(grant_log.size()), 64'(2));
      check_burst(0, 1, 2);
      check_burst(1, 3, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
